// File: rtl/microarchtrace_pkg.sv
// Shared types for the microarchitecture trace event scheduler: source and
// kind encodings, the buffered event record and the default FIFO depth.
package microarchtrace_pkg;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_EX = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        IF_SINGLE = 2'd0,
        IF_START  = 2'd1,
        IF_END    = 2'd2
    } if_kind_e;

    typedef enum logic [1:0] {
        EX_SINGLE     = 2'd0,
        EX_MULT_START = 2'd1,
        EX_MULT_END   = 2'd2
    } ex_kind_e;

    // One buffered trace event; ID/EX events carry zero insn/c/c_insn.
    typedef struct packed {
        logic        src;
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        c;
        logic [15:0] c_insn;
        logic [31:0] ts;
    } evt_t;

    localparam int DEFAULT_DEPTH = 4;

    // Wrap-aware age test: a is older than b when (a - b) is negative.
    function automatic logic ts_older(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        diff = a - b;
        return diff[31];
    endfunction

endpackage

// File: rtl/microarchtrace_evt_fifo.sv
// Circular FIFO of trace events. Accepts a push while full as long as the
// head is popped in the same cycle. DEPTH must be a power of two, >= 2.
module microarchtrace_evt_fifo
    import microarchtrace_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  evt_t din,
    output evt_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    evt_t          mem_q [DEPTH];
    evt_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset flushes the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/microarchtrace_evt_sched.sv
// Trace event scheduler: buffers fetch and ID/EX events in per-source FIFOs,
// timestamps them and serializes them onto one valid/ready stream with loss
// accounting.
// Optional feature macro MICROARCHTRACE_TS_ORDER_EN: when defined, the older
// head (wrap-aware timestamp compare, ties to ID/EX) is emitted first; when
// undefined, the two sources are served round-robin starting with ID/EX.
module microarchtrace_evt_sched
    import microarchtrace_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             if_valid,
    input  logic [1:0]       if_kind,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_insn,
    input  logic             if_c,
    input  logic [15:0]      if_c_insn,
    input  logic             ex_valid,
    input  logic [1:0]       ex_kind,
    input  logic [31:0]      ex_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [1:0]       out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_insn,
    output logic             out_c,
    output logic [15:0]      out_c_insn,
    output logic [31:0]      out_ts,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    logic [31:0]      ts_q, ts_d;
    evt_t             if_evt, ex_evt, if_head, ex_head;
    logic             if_full, if_empty, ex_full, ex_empty;
    logic             if_push, ex_push, if_pop, ex_pop;
    logic             if_drop, ex_drop;
    logic             load, sel_ex;
    evt_t             out_evt_q, out_evt_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    // Adds up to two drops to the loss counter, sticking at all-ones.
    function automatic logic [CNT_W-1:0] sat_add2(input logic [CNT_W-1:0] cnt,
                                                  input logic a, input logic b);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{CNT_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Build the records to enqueue, stamped with the current timestamp.
    always_comb begin
        if_evt        = '0;
        if_evt.src    = SRC_IF;
        if_evt.kind   = if_kind;
        if_evt.pc     = if_pc;
        if_evt.insn   = if_insn;
        if_evt.c      = if_c;
        if_evt.c_insn = if_c_insn;
        if_evt.ts     = ts_q;
        ex_evt        = '0;
        ex_evt.src    = SRC_EX;
        ex_evt.kind   = ex_kind;
        ex_evt.pc     = ex_pc;
        ex_evt.ts     = ts_q;
    end

    microarchtrace_evt_fifo #(.DEPTH(DEPTH)) u_if_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (if_push),
        .pop   (if_pop),
        .din   (if_evt),
        .dout  (if_head),
        .full  (if_full),
        .empty (if_empty)
    );

    microarchtrace_evt_fifo #(.DEPTH(DEPTH)) u_ex_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ex_push),
        .pop   (ex_pop),
        .din   (ex_evt),
        .dout  (ex_head),
        .full  (ex_full),
        .empty (ex_empty)
    );

`ifndef MICROARCHTRACE_TS_ORDER_EN
    logic last_grant_ex_q, last_grant_ex_d;

    // Remember which source was served last so the next grant alternates.
    always_comb begin
        last_grant_ex_d = last_grant_ex_q;
        if (if_pop || ex_pop) begin
            last_grant_ex_d = ex_pop;
        end
    end

    // Reset to "fetch served last" so ID/EX wins the first contested slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_ex_q <= 1'b0;
        end else begin
            last_grant_ex_q <= last_grant_ex_d;
        end
    end
`endif

    // Choose which FIFO head feeds the output slot.
    always_comb begin
        sel_ex = 1'b0;
        if (!ex_empty && if_empty) begin
            sel_ex = 1'b1;
        end else if (!ex_empty && !if_empty) begin
`ifdef MICROARCHTRACE_TS_ORDER_EN
            sel_ex = !ts_older(if_head.ts, ex_head.ts);
`else
            sel_ex = !last_grant_ex_q;
`endif
        end
    end

    // Pops follow slot loads; pushes may reuse a slot freed by a same-cycle pop.
    always_comb begin
        load    = !out_valid_q || out_ready;
        if_pop  = load && !if_empty && !sel_ex;
        ex_pop  = load && sel_ex;
        if_push = if_valid && enable && (!if_full || if_pop);
        ex_push = ex_valid && enable && (!ex_full || ex_pop);
        if_drop = if_valid && enable && if_full && !if_pop;
        ex_drop = ex_valid && enable && ex_full && !ex_pop;
    end

    // Output slot, timestamp and loss accounting next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_evt_d   = out_evt_q;
        if (load) begin
            out_valid_d = !if_empty || !ex_empty;
            if (!if_empty || !ex_empty) begin
                out_evt_d = sel_ex ? ex_head : if_head;
            end
        end
        ts_d       = enable ? ts_q + 32'd1 : ts_q;
        drop_cnt_d = sat_add2(drop_cnt_q, if_drop, ex_drop);
        overflow_d = overflow_q || if_drop || ex_drop;
    end

    // Registers; asynchronous reset clears out_valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_evt_q   <= '0;
            ts_q        <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_evt_q   <= out_evt_d;
            ts_q        <= ts_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_src    = out_evt_q.src;
    assign out_kind   = out_evt_q.kind;
    assign out_pc     = out_evt_q.pc;
    assign out_insn   = out_evt_q.insn;
    assign out_c      = out_evt_q.c;
    assign out_c_insn = out_evt_q.c_insn;
    assign out_ts     = out_evt_q.ts;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_microarchtrace_evt_sched.sv
// Scoreboard bench for microarchtrace_evt_sched: a queue-based reference
// model predicts the emitted event stream; a negedge monitor compares every
// transfer against it.
module tb_microarchtrace_evt_sched;
    import microarchtrace_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             if_valid;
    logic [1:0]       if_kind;
    logic [31:0]      if_pc;
    logic [31:0]      if_insn;
    logic             if_c;
    logic [15:0]      if_c_insn;
    logic             ex_valid;
    logic [1:0]       ex_kind;
    logic [31:0]      ex_pc;
    logic             out_valid;
    logic             out_ready;
    logic             out_src;
    logic [1:0]       out_kind;
    logic [31:0]      out_pc;
    logic [31:0]      out_insn;
    logic             out_c;
    logic [15:0]      out_c_insn;
    logic [31:0]      out_ts;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    always #5 clk = ~clk;

    microarchtrace_evt_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .if_valid   (if_valid),
        .if_kind    (if_kind),
        .if_pc      (if_pc),
        .if_insn    (if_insn),
        .if_c       (if_c),
        .if_c_insn  (if_c_insn),
        .ex_valid   (ex_valid),
        .ex_kind    (ex_kind),
        .ex_pc      (ex_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .out_kind   (out_kind),
        .out_pc     (out_pc),
        .out_insn   (out_insn),
        .out_c      (out_c),
        .out_c_insn (out_c_insn),
        .out_ts     (out_ts),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    evt_t        m_ifq[$];
    evt_t        m_exq[$];
    evt_t        exp_q[$];
    bit          m_slot_v;
    bit          m_last_ex;
    logic [31:0] m_ts;
    int          m_drops;
    bit          m_ovf;
    bit          exp_valid_now;

    // Monitor observations
    int          xfer_cnt;
    logic        src_log[$];
    logic [31:0] last_ts;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ifq.delete();
        m_exq.delete();
        exp_q.delete();
        m_slot_v      = 1'b0;
        m_last_ex     = 1'b0;
        m_ts          = '0;
        m_drops       = 0;
        m_ovf         = 1'b0;
        exp_valid_now = 1'b0;
    endtask

    // Predict what the next rising edge does, from the current inputs.
    task automatic step();
        bit          sel_ex;
        evt_t        e;
        logic [31:0] d;
        int          nd;
        exp_valid_now = m_slot_v;
        sel_ex = 1'b0;
        if (m_exq.size() > 0 && m_ifq.size() == 0) begin
            sel_ex = 1'b1;
        end else if (m_exq.size() > 0 && m_ifq.size() > 0) begin
`ifdef MICROARCHTRACE_TS_ORDER_EN
            d = m_ifq[0].ts - m_exq[0].ts;
            sel_ex = !($signed(d) < 0);
`else
            d = '0;
            sel_ex = !m_last_ex;
`endif
        end
        if (!m_slot_v || out_ready) begin
            if (m_ifq.size() == 0 && m_exq.size() == 0) begin
                m_slot_v = 1'b0;
            end else begin
                e = sel_ex ? m_exq.pop_front() : m_ifq.pop_front();
                exp_q.push_back(e);
                m_slot_v  = 1'b1;
                m_last_ex = sel_ex;
            end
        end
        nd = 0;
        if (enable && if_valid) begin
            if (m_ifq.size() < DEPTH)
                m_ifq.push_back('{src: 1'b0, kind: if_kind, pc: if_pc, insn: if_insn,
                                  c: if_c, c_insn: if_c_insn, ts: m_ts});
            else
                nd++;
        end
        if (enable && ex_valid) begin
            if (m_exq.size() < DEPTH)
                m_exq.push_back('{src: 1'b1, kind: ex_kind, pc: ex_pc, insn: 32'd0,
                                  c: 1'b0, c_insn: 16'd0, ts: m_ts});
            else
                nd++;
        end
        if (nd > 0) m_ovf = 1'b1;
        m_drops = (m_drops + nd > CNT_MAX) ? CNT_MAX : m_drops + nd;
        if (enable) m_ts = m_ts + 32'd1;
    endtask

    // One clock cycle: wait for the edge, release any pending reset, drive, model.
    task automatic drive(input bit en, input bit rdy,
                         input bit iv, input logic [1:0] ik, input logic [31:0] ipc,
                         input logic [31:0] iinsn, input bit ic, input logic [15:0] ici,
                         input bit ev, input logic [1:0] ek, input logic [31:0] epc);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        enable    = en;
        out_ready = rdy;
        if_valid  = iv;
        if_kind   = ik;
        if_pc     = ipc;
        if_insn   = iinsn;
        if_c      = ic;
        if_c_insn = ici;
        ex_valid  = ev;
        ex_kind   = ek;
        ex_pc     = epc;
        step();
    endtask

    task automatic idle(input bit en, input bit rdy);
        drive(en, rdy, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        if_valid  = 1'b0;
        ex_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    // Monitor: compare every accepted output against the scoreboard.
    always @(negedge clk) begin
        evt_t e;
        if (!rst) begin
            check("out_valid", {127'd0, out_valid}, {127'd0, exp_valid_now});
            if (out_valid && out_ready) begin
                xfer_cnt++;
                src_log.push_back(out_src);
                last_ts = out_ts;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got pc 0x%0h expected no event", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {12'd0, out_src, out_kind, out_pc, out_insn, out_c,
                                    out_c_insn, out_ts}, {12'd0, e});
                end
            end
        end
    end

    initial begin
        logic [66:0] held;
        rst = 1'b1;
        enable = 1'b0; out_ready = 1'b0;
        if_valid = 1'b0; if_kind = '0; if_pc = '0; if_insn = '0; if_c = 1'b0; if_c_insn = '0;
        ex_valid = 1'b0; ex_kind = '0; ex_pc = '0;
        xfer_cnt = 0; last_ts = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_src", {127'd0, out_src}, 128'd0);
        check("rst_out_kind", {126'd0, out_kind}, 128'd0);
        check("rst_out_pc", {96'd0, out_pc}, 128'd0);
        check("rst_out_insn", {96'd0, out_insn}, 128'd0);
        check("rst_out_c", {127'd0, out_c}, 128'd0);
        check("rst_out_c_insn", {112'd0, out_c_insn}, 128'd0);
        check("rst_out_ts", {96'd0, out_ts}, 128'd0);
        check("rst_drop_cnt", {124'd0, drop_cnt}, 128'd0);
        check("rst_overflow", {127'd0, overflow}, 128'd0);

        // Single fetch event stamped ts=5, one cycle of latency
        idle(1'b1, 1'b1);
        repeat (4) idle(1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h80, 32'h13, 1'b0, 16'd0, 1'b0, 2'd0, 32'd0);
        idle(1'b1, 1'b1);
        #1;
        check("single_not_yet", {127'd0, out_valid}, 128'd0);
        idle(1'b1, 1'b1);
        #1;
        check("single_valid", {127'd0, out_valid}, 128'd1);
        check("single_ts", {96'd0, out_ts}, 128'd5);
        check("single_pc", {96'd0, out_pc}, 128'h80);
        check("single_src_kind", {125'd0, out_src, out_kind}, 128'd0);
        repeat (3) idle(1'b1, 1'b1);

`ifdef MICROARCHTRACE_TS_ORDER_EN
        // Simultaneous events: ID/EX wins the tie, both carry ts=10
        do_reset();
        idle(1'b1, 1'b1);
        repeat (9) idle(1'b1, 1'b1);
        src_log.delete();
        drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h84, 32'h13, 1'b0, 16'd0, 1'b1, 2'd0, 32'h100);
        repeat (5) idle(1'b1, 1'b1);
        check("tie_count", 128'(src_log.size()), 128'd2);
        if (src_log.size() >= 2) begin
            check("tie_first_ex", {127'd0, src_log[0]}, 128'd1);
            check("tie_second_if", {127'd0, src_log[1]}, 128'd0);
        end
`else
        // Both sources busy: round-robin alternates starting with ID/EX
        do_reset();
        idle(1'b1, 1'b1);
        src_log.delete();
        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b1, 1'b1, 2'(i % 3), 32'h400 + 32'(4 * i), 32'h1000 + 32'(i),
                  i[0], 16'(i), 1'b1, 2'((i + 1) % 3), 32'h800 + 32'(4 * i));
        repeat (14) idle(1'b1, 1'b1);
        check("rr_count", {127'd0, src_log.size() >= 6}, 128'd1);
        for (int i = 0; i < 6 && i < src_log.size(); i++)
            check("rr_src", {127'd0, src_log[i]}, {127'd0, ~i[0]});
`endif

        // Backpressure then a burst of 8 fetch events: 5 kept, 3 dropped
        do_reset();
        idle(1'b1, 1'b0);
        repeat (19) idle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b0, 1'b1, 2'd1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i),
                  1'b1, 16'hC000 + 16'(i), 1'b0, 2'd0, 32'd0);
        xfer_cnt = 0;
        idle(1'b1, 1'b0);
        #1;
        check("ovf_drop_cnt", {124'd0, drop_cnt}, 128'd3);
        check("ovf_flag", {127'd0, overflow}, 128'd1);
        check("ovf_slot_pc", {96'd0, out_pc}, 128'h1000);
        held = {out_src, out_kind, out_pc, out_ts};
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0);
            #1;
            check("stall_payload", {61'd0, out_src, out_kind, out_pc, out_ts}, {61'd0, held});
            check("stall_valid", {127'd0, out_valid}, 128'd1);
        end
        check("stall_no_xfer", 128'(xfer_cnt), 128'd0);
        repeat (10) idle(1'b1, 1'b1);
        check("drain_count", 128'(xfer_cnt), 128'd5);
        check("drain_sb_empty", 128'(exp_q.size()), 128'd0);

        // Reset while both FIFOs and the output slot hold events
        do_reset();
        idle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h2000 + 32'(i), 32'h13, 1'b0, 16'd0,
                  1'b1, 2'd2, 32'h3000 + 32'(i));
        #1;
        check("pre_rst_valid", {127'd0, out_valid}, 128'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {127'd0, out_valid}, 128'd0);
        check("async_rst_drop", {124'd0, drop_cnt}, 128'd0);
        model_reset();
        repeat (2) @(posedge clk);
        xfer_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b1, 2'd0, 32'h200);
        repeat (5) idle(1'b1, 1'b1);
        check("post_rst_xfers", 128'(xfer_cnt), 128'd1);
        check("post_rst_ts", {96'd0, last_ts}, 128'd0);

        // Randomized traffic against the reference model
        do_reset();
        idle(1'b1, 1'b1);
        for (int i = 0; i < 1500; i++)
            drive(($urandom % 8) != 0, ($urandom % 3) != 0,
                  $urandom % 2, 2'($urandom_range(0, 2)), $urandom, $urandom,
                  $urandom % 2, 16'($urandom),
                  $urandom % 2, 2'($urandom_range(0, 2)), $urandom);
        repeat (20) idle(1'b0, 1'b1);
        #1;
        check("rand_sb_empty", 128'(exp_q.size()), 128'd0);
        check("rand_drop_cnt", {124'd0, drop_cnt}, 128'(m_drops));
        check("rand_overflow", {127'd0, overflow}, {127'd0, m_ovf});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microarchtrace_evt_sched.md
# microarchtrace_evt_sched

Synthesizable event scheduler for the microarchitecture trace path. It takes classified trace events from two concurrent producers, buffers each in its own FIFO and serializes them onto one valid/ready event stream. The producers are the fetch-stage monitor and the ID/EX-stage monitor. It sits between the per-core trace probes and the trace sink (DPI bridge in simulation, trace buffer on FPGA), and it guarantees ordering and reports loss.

## Interface
Parameters:
- DEPTH, 4: entries per source FIFO; power of two, ≥2.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable. While low, no events are enqueued and the timestamp holds.
- if_valid  in  1  fetch event present this cycle. No backpressure.
- if_kind  in  2  IF_SINGLE=0, IF_START=1, IF_END=2.
- if_pc  in  32  fetch PC.
- if_insn  in  32  fetched instruction.
- if_c  in  1  instruction was compressed.
- if_c_insn  in  16  compressed encoding.
- ex_valid  in  1  ID/EX event present this cycle. No backpressure.
- ex_kind  in  2  EX_SINGLE=0, EX_MULT_START=1, EX_MULT_END=2.
- ex_pc  in  32  executing PC.
- out_valid  out  1  output event valid. Reset 0.
- out_ready  in  1  sink accepts.
- out_src  out  1  0 = fetch, 1 = ID/EX. Reset 0.
- out_kind  out  2  event kind. Reset 0.
- out_pc, out_insn  out  32 each  payload. Reset 0. out_insn is 0 for ID/EX events.
- out_c  out  1  payload. Reset 0. 0 for ID/EX events.
- out_c_insn  out  16  payload. Reset 0. 0 for ID/EX events.
- out_ts  out  32  capture timestamp. Reset 0.
- drop_cnt  out  CNT_W  events lost to full FIFOs, saturating. Reset 0.
- overflow  out  1  sticky; set on first drop. Reset 0.

## Operation
- Capture: an event is pushed into its source FIFO on a rising edge when it meets all of the following:
  - src_valid is 1,
  - enable is 1,
  - the FIFO is not full, or that FIFO is popped in the same cycle.
- Each pushed entry is stamped with the current ts_q.
- Drop: a valid, enabled event that arrives at a full FIFO with no simultaneous pop is discarded.
  - drop_cnt increments, saturating at all-ones.
  - overflow sets and stays set until reset.
  - If both sources drop in the same cycle, drop_cnt increases by 2, saturating.
- Timestamp: ts_q is a 32-bit free-running counter, +1 per cycle while enable=1. It wraps from 0xFFFFFFFF to 0.
- Output stage: one register slot. It loads when it is empty, or when out_valid && out_ready. Loading pops the selected FIFO head.
- Payload stays stable while out_valid && !out_ready.
- Selection: see Configuration. When only one FIFO is non-empty, that FIFO is selected.
- Reset mid-operation:
  - both FIFOs are flushed and the output slot is cleared;
  - out_valid drops immediately (asynchronously);
  - counters, flags and ts_q return to 0.

## Timing
- Event sampled at edge N is written into its FIFO.
- At edge N+1 it can load the output slot, so out_valid is high in cycle N+1 at the earliest. Minimum latency: 1 cycle.
- Sustained throughput is one event per cycle. Two sources each producing one event per cycle overflow after about DEPTH cycles.
- Both FIFO states are registered, so out_valid never depends combinationally on if_valid or ex_valid.
- The output handshake is standard valid/ready: a transfer happens in the cycle where both are high.

## Configuration
- MICROARCHTRACE_TS_ORDER_EN defined: selection picks the older head by wrap-aware comparison. A is older when $signed(ts_A − ts_B) < 0.
  - Equal timestamps go to ID/EX first, then fetch.
  - The output stream is globally ordered by timestamp.
- Not defined: round-robin between the non-empty FIFOs.
  - A last-grant pointer alternates; after reset it favours ID/EX.
  - out_ts is still driven.
  - Ordering is guaranteed only within each source.

## Structure
- microarchtrace_pkg: source, if-kind and ex-kind enums; evt_t struct (src, kind, pc, insn, c, c_insn, ts); default DEPTH.
- Sub-module microarchtrace_evt_fifo: parameterized evt_t FIFO with push, pop, full, empty and same-cycle push/pop when full. It is instantiated twice.
- Top level holds the timestamp counter, selection logic, output slot and drop accounting.

## Test plan
- Reset, enable=1, single IF_SINGLE event with pc=0x80 and insn=0x00000013 at cycle 5, out_ready=1 → out_valid in cycle 6 with src=0, kind=0, pc=0x80 and ts=5; then idle.
- With the macro defined, IF event and ex_pc=0x100 EX_SINGLE in the same cycle (ts=10) → ID/EX emitted first, then fetch the next cycle; both carry ts=10.
- out_ready=0 for 20 cycles, then 1 IF event per cycle for 8 cycles, DEPTH=4 → FIFO holds 4, output slot holds 1, drop_cnt=3, overflow=1. After out_ready=1, exactly 5 events drain in order.
- Stall out_ready for 3 cycles while out_valid=1 → payload unchanged across the stall; the transfer happens only on the ready cycle.
- Assert rst while both FIFOs hold entries and out_valid=1 → out_valid=0 in the same cycle; after release, no stale events appear; drop_cnt=0 and ts restarts at 0.
- Without the macro, both FIFOs kept non-empty → out_src alternates 1,0,1,0… starting with ID/EX.
